// File: rtl/ff_frame_pkg.sv
// Shared types and constants for the FIFO frame writer.
// Frames on the FIFO are: sequence header, payload words, XOR trailer.
package ff_frame_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_LEN    = 16;

    // Tag stored alongside the slot word; marks the frame's closing word.
    localparam logic TAG_DATA    = 1'b0;
    localparam logic TAG_TRAILER = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        TRAILER,
        DRAIN
    } state_t;
endpackage

// File: rtl/ff_out_slot.sv
// Single-entry holding register driving the FIFO write port.
// A loaded word stays put until the FIFO takes it; frame_done follows a taken trailer.
module ff_out_slot
    import ff_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_tag,
    input  logic                  wr_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  slot_free,
    output logic                  frame_done
);
    logic tag;

    // Free when empty, or when the current word leaves on this edge.
    assign slot_free = !wr_en || !wr_full;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            tag        <= TAG_DATA;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wr_en && !wr_full && (tag == TAG_TRAILER);
            if (load) begin
                wr_en   <= 1'b1;
                wr_data <= load_data;
                tag     <= load_tag;
            end else if (slot_free) begin
                wr_en <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/fifo_frame_writer.sv
// Write-domain framer: wraps each input stream frame as header, payload, XOR trailer
// and pushes it into the dual-clock FIFO, truncating frames longer than MAX_LEN.
module fifo_frame_writer
    import ff_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int LEN_BITS   = $clog2(MAX_LEN + 1)
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_full,
    output logic                  frame_done,
    output logic                  err_trunc,
    output logic [DATA_WIDTH-1:0] seq_num
);
    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] checksum;
    logic [LEN_BITS-1:0]   count;
    logic                  trunc;
    logic                  slot_free, slot_load, slot_tag;
    logic [DATA_WIDTH-1:0] slot_data;
    logic                  at_max;

    assign at_max = (count == LEN_BITS'(MAX_LEN - 1));

    ff_out_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .wr_clk     (wr_clk),
        .wr_rst_n   (wr_rst_n),
        .load       (slot_load),
        .load_data  (slot_data),
        .load_tag   (slot_tag),
        .wr_full    (wr_full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .slot_free  (slot_free),
        .frame_done (frame_done)
    );

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid && slot_free) state_nxt = PAYLOAD;
            PAYLOAD: if (s_valid && slot_free && (s_last || at_max)) state_nxt = TRAILER;
            TRAILER: if (slot_free) state_nxt = trunc ? DRAIN : IDLE;
            DRAIN:   if (s_valid && s_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // s_ready only looks at wr_full through slot_free, never at s_valid.
    always_comb begin
        s_ready   = 1'b0;
        slot_load = 1'b0;
        slot_data = seq_num;
        slot_tag  = TAG_DATA;
        case (state)
            IDLE:    slot_load = s_valid && slot_free;
            PAYLOAD: begin
                s_ready   = slot_free;
                slot_load = s_valid && slot_free;
                slot_data = s_data;
            end
            TRAILER: begin
                slot_load = slot_free;
                slot_data = checksum;
                slot_tag  = TAG_TRAILER;
            end
            DRAIN:   s_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            seq_num   <= '0;
            checksum  <= '0;
            count     <= '0;
            trunc     <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            case (state)
                IDLE: if (slot_load) begin
                    checksum <= seq_num;
                    count    <= '0;
                end
                PAYLOAD: if (slot_load) begin
                    checksum <= checksum ^ s_data;
                    count    <= count + LEN_BITS'(1);
                    if (!s_last && at_max) begin
                        trunc     <= 1'b1;
                        err_trunc <= 1'b1;
                    end
                end
                TRAILER: if (slot_load) seq_num <= seq_num + DATA_WIDTH'(1);
                DRAIN:   if (s_valid && s_last) trunc <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer: expected FIFO words go into a scoreboard
// queue; a negedge monitor pops and compares every word the FIFO takes.
module tb_fifo_frame_writer;
    localparam int DW = 8;
    localparam int ML = 16;
    typedef logic [DW-1:0] word_q_t[$];

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          wr_full = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, wr_en, frame_done, err_trunc;
    logic [DW-1:0] wr_data, seq_num;

    int total = 0, bad = 0, cyc = 0, n_fd = 0, n_trunc = 0;
    logic [DW:0] exp_q[$];   // {is_trailer, data}
    int          take_cyc[$];
    logic        fd_pend = 1'b0;

    fifo_frame_writer #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .frame_done(frame_done), .err_trunc(err_trunc), .seq_num(seq_num)
    );

    always #5 wr_clk = ~wr_clk;
    always @(posedge wr_clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a write is taken on the coming posedge when wr_en && !wr_full here.
    always @(negedge wr_clk) begin
        if (wr_rst_n) begin
            if (frame_done || fd_pend) chk("frame_done", {31'b0, frame_done}, {31'b0, fd_pend});
            if (frame_done) n_fd++;
            if (err_trunc) n_trunc++;
            fd_pend = 1'b0;
            if (wr_en && !wr_full) begin
                take_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_write: data %0h with nothing expected", wr_data);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("wr_data", {24'b0, wr_data}, {24'b0, e[DW-1:0]});
                    fd_pend = e[DW];
                end
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = last;
        do begin @(negedge wr_clk); t++; end while (!s_ready && t < 200);
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL s_ready_timeout: word %0h never accepted", d);
        end
        @(posedge wr_clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input word_q_t w);
        for (int i = 0; i < w.size(); i++) push_word(w[i], i == w.size() - 1);
    endtask

    task automatic expect_frame(input logic [DW-1:0] seq, input word_q_t w);
        logic [DW-1:0] x;
        x = seq;
        exp_q.push_back({1'b0, seq});
        for (int i = 0; i < w.size() && i < ML; i++) begin
            exp_q.push_back({1'b0, w[i]});
            x ^= w[i];
        end
        exp_q.push_back({1'b1, x});
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(posedge wr_clk); t++; end
        chk({nm, "_drained"}, exp_q.size(), 0);
        repeat (2) @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge wr_clk); #1 wr_rst_n = 1'b0;
        @(posedge wr_clk); #1 wr_rst_n = 1'b1;
    endtask

    initial begin
        word_q_t f;
        logic [DW-1:0] held;
        int fd0, tr0;

        #2;
        chk("rst_wr_en", {31'b0, wr_en}, 0);
        chk("rst_wr_data", {24'b0, wr_data}, 0);
        chk("rst_s_ready", {31'b0, s_ready}, 0);
        chk("rst_seq_num", {24'b0, seq_num}, 0);
        chk("rst_pulses", {30'b0, frame_done, err_trunc}, 0);
        @(posedge wr_clk); #1 wr_rst_n = 1'b1;

        // Single 3-word frame: five back-to-back writes.
        take_cyc.delete(); fd0 = n_fd;
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b1, 8'h00});
        f = '{8'h11, 8'h22, 8'h33};
        send_frame(f);
        drain("t1");
        chk("t1_writes", take_cyc.size(), 5);
        if (take_cyc.size() == 5) chk("t1_span", take_cyc[4] - take_cyc[0], 4);
        chk("t1_frames", n_fd - fd0, 1);
        chk("t1_seq", {24'b0, seq_num}, 1);

        // Two back-to-back frames after reset.
        do_reset();
        take_cyc.delete(); fd0 = n_fd;
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'hA5});
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h0F});
        exp_q.push_back({1'b0, 8'hF0}); exp_q.push_back({1'b1, 8'hFE});
        f = '{8'hA5};
        send_frame(f);
        f = '{8'h0F, 8'hF0};
        send_frame(f);
        drain("t2");
        chk("t2_writes", take_cyc.size(), 7);
        if (take_cyc.size() == 7) chk("t2_span", take_cyc[6] - take_cyc[0], 6);
        chk("t2_frames", n_fd - fd0, 2);
        chk("t2_seq", {24'b0, seq_num}, 2);

        // Backpressure for 4 cycles mid-payload.
        exp_q.push_back({1'b0, 8'h02});
        for (int i = 1; i <= 6; i++) exp_q.push_back({1'b0, 8'(i)});
        exp_q.push_back({1'b1, 8'h05});
        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fork
            send_frame(f);
            begin
                repeat (3) @(posedge wr_clk);
                #1 wr_full = 1'b1;
                @(negedge wr_clk);
                held = wr_data;
                chk("t3_stall_word", {24'b0, held}, 8'h02);
                chk("t3_stall_ready", {31'b0, s_ready}, 0);
                repeat (3) begin
                    @(negedge wr_clk);
                    chk("t3_stall_hold", {24'b0, wr_data}, {24'b0, held});
                    chk("t3_stall_ready", {31'b0, s_ready}, 0);
                end
                @(posedge wr_clk); #1 wr_full = 1'b0;
            end
        join
        drain("t3");

        // 20-word frame truncated to 16, then a normal frame.
        tr0 = n_trunc; fd0 = n_fd;
        f.delete();
        for (int i = 0; i < 20; i++) f.push_back(8'(8'h31 + i));
        expect_frame(8'h03, f);
        send_frame(f);
        f = '{8'h99};
        expect_frame(8'h04, f);
        send_frame(f);
        drain("t4");
        chk("t4_trunc_pulses", n_trunc - tr0, 1);
        chk("t4_frames", n_fd - fd0, 2);
        chk("t4_seq", {24'b0, seq_num}, 5);

        // Reset mid-payload while the FIFO is full.
        wr_full = 1'b1;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
        @(posedge wr_clk); @(negedge wr_clk);
        chk("t5_hdr_loaded", {24'b0, wr_data}, 8'h05);
        chk("t5_hdr_wr_en", {31'b0, wr_en}, 1);
        #1 wr_rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", {31'b0, wr_en}, 0);
        chk("t5_rst_wr_data", {24'b0, wr_data}, 0);
        chk("t5_rst_s_ready", {31'b0, s_ready}, 0);
        chk("t5_rst_seq", {24'b0, seq_num}, 0);
        @(posedge wr_clk); #1;
        s_valid = 1'b0; wr_full = 1'b0; wr_rst_n = 1'b1;
        exp_q.push_back({1'b0, 8'h00}); exp_q.push_back({1'b0, 8'h77});
        exp_q.push_back({1'b1, 8'h77});
        f = '{8'h77};
        send_frame(f);
        drain("t5");
        chk("t5_seq", {24'b0, seq_num}, 1);

        // Sequence wrap over 256 single-word frames.
        do_reset();
        fd0 = n_fd;
        for (int i = 0; i < 256; i++) begin
            f = '{8'(i) ^ 8'h3C};
            expect_frame(8'(i), f);
            send_frame(f);
        end
        drain("t6");
        chk("t6_frames", n_fd - fd0, 256);
        chk("t6_seq_wrap", {24'b0, seq_num}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
